// File: rtl/alu_exec_pkg.sv
// Shared opcode encodings, FSM state type and opcode-class helpers for the ALU execute stage.
// ALU_MUL_EN selects whether opcode 16 is the iterative multiply or a reserved opcode.
package alu_exec_pkg;

  localparam logic [4:0] OP_AND = 5'd0;
  localparam logic [4:0] OP_EOR = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_RSB = 5'd3;
  localparam logic [4:0] OP_ADD = 5'd4;
  localparam logic [4:0] OP_ADC = 5'd5;
  localparam logic [4:0] OP_SBC = 5'd6;
  localparam logic [4:0] OP_RSC = 5'd7;
  localparam logic [4:0] OP_TST = 5'd8;
  localparam logic [4:0] OP_TEQ = 5'd9;
  localparam logic [4:0] OP_CMP = 5'd10;
  localparam logic [4:0] OP_CMN = 5'd11;
  localparam logic [4:0] OP_ORR = 5'd12;
  localparam logic [4:0] OP_MOV = 5'd13;
  localparam logic [4:0] OP_BIC = 5'd14;
  localparam logic [4:0] OP_MVN = 5'd15;
  localparam logic [4:0] OP_MUL = 5'd16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic is_arith(input logic [4:0] op);
    return ((op >= OP_SUB) && (op <= OP_RSC)) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  // Compare/test ops only set flags and never write the register file.
  function automatic logic is_compare(input logic [4:0] op);
    return (op >= OP_TST) && (op <= OP_CMN);
  endfunction

  function automatic logic is_reserved(input logic [4:0] op);
`ifdef ALU_MUL_EN
    return op > OP_MUL;
`else
    return op >= OP_MUL;
`endif
  endfunction

endpackage

// File: rtl/alu_exec_unit_core.sv
// Combinational result and NZCV for opcodes 0-15; any other opcode yields a zero result.
module alu_comb_core
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_res,
  output logic             o_n,
  output logic             o_z,
  output logic             o_c,
  output logic             o_v,
  output logic             o_v_upd
);

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_ci;
  logic [WIDTH-1:0] w_logic;
  logic [WIDTH:0]   w_sum;
  logic             w_arith;

  always_comb begin
    w_x     = i_a;
    w_y     = i_b;
    w_ci    = 1'b0;
    w_logic = '0;
    // Subtraction is x + ~y + 1; the reverse forms swap the operands first.
    case (i_op)
      OP_SUB, OP_CMP: begin w_y = ~i_b; w_ci = 1'b1; end
      OP_RSB:         begin w_x = i_b; w_y = ~i_a; w_ci = 1'b1; end
      OP_ADC:         w_ci = i_cin;
      OP_SBC:         begin w_y = ~i_b; w_ci = i_cin; end
      OP_RSC:         begin w_x = i_b; w_y = ~i_a; w_ci = i_cin; end
      OP_AND, OP_TST: w_logic = i_a & i_b;
      OP_EOR, OP_TEQ: w_logic = i_a ^ i_b;
      OP_ORR:         w_logic = i_a | i_b;
      OP_MOV:         w_logic = i_b;
      OP_BIC:         w_logic = i_a & ~i_b;
      OP_MVN:         w_logic = ~i_b;
      default:        w_logic = '0;
    endcase
  end

  assign w_arith = is_arith(i_op);
  assign w_sum   = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_ci};
  assign o_res   = w_arith ? w_sum[WIDTH-1:0] : w_logic;
  assign o_n     = o_res[WIDTH-1];
  assign o_z     = (o_res == '0);
  assign o_c     = w_arith ? w_sum[WIDTH] : i_cin;
  assign o_v     = w_arith && (w_x[WIDTH-1] == w_y[WIDTH-1]) && (o_res[WIDTH-1] != w_x[WIDTH-1]);
  assign o_v_upd = w_arith;

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execute stage: opcode mux, output register, PSR and (with ALU_MUL_EN defined)
// an iterative shift-add multiplier sequenced by a two-state FSM.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter bit CIN_FROM_PSR = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carry_in,
  input  logic             sel_src,
  input  logic [4:0]       sel_alu,
  input  logic [4:0]       sel_cu,
  input  logic             psr_load,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wr_en,
  output logic             N,
  output logic             Zero,
  output logic             C,
  output logic             V
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_wr_en;
  logic             r_n, r_z, r_c, r_v;

  logic [4:0]       w_op;
  logic             w_cin;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_idle;
  logic [WIDTH-1:0] w_res;
  logic             w_n, w_z, w_c, w_v, w_v_upd;

  assign w_op     = sel_src ? sel_cu : sel_alu;
  assign w_cin    = CIN_FROM_PSR ? r_c : carry_in;
  assign in_ready = w_idle && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .i_op    (w_op),
    .i_a     (A),
    .i_b     (B),
    .i_cin   (w_cin),
    .o_res   (w_res),
    .o_n     (w_n),
    .o_z     (w_z),
    .o_c     (w_c),
    .o_v     (w_v),
    .o_v_upd (w_v_upd)
  );

`ifdef ALU_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_psr_ld;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_prod;

  assign w_is_mul   = (w_op == OP_MUL);
  assign w_idle     = (r_state == ST_IDLE);
  assign w_mul_done = (r_state == ST_BUSY) && (r_cnt == CNT_LAST);
  assign w_prod     = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_is_mul) w_state_nxt = ST_BUSY;
      ST_BUSY: if (r_cnt == CNT_LAST) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Multiplier datapath: one multiplier bit consumed per BUSY cycle.
  always_ff @(posedge Clk) begin
    if (w_accept && w_is_mul) begin
      r_mcand  <= A;
      r_mplier <= B;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_psr_ld <= psr_load;
    end else if (r_state == ST_BUSY) begin
      r_acc    <= w_prod;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`else
  assign w_is_mul = 1'b0;
  assign w_idle   = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_wr_en     <= 1'b0;
      r_n         <= 1'b0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_accept && !w_is_mul) begin
        r_out_valid <= 1'b1;
        r_result    <= w_res;
        r_wr_en     <= !is_compare(w_op) && !is_reserved(w_op);
        if (psr_load && !is_reserved(w_op)) begin
          r_n <= w_n;
          r_z <= w_z;
          r_c <= w_c;
          if (w_v_upd) r_v <= w_v;
        end
      end
`ifdef ALU_MUL_EN
      if (w_mul_done) begin
        r_out_valid <= 1'b1;
        r_result    <= w_prod;
        r_wr_en     <= 1'b1;
        if (r_psr_ld) begin
          r_n <= w_prod[WIDTH-1];
          r_z <= (w_prod == '0);
        end
      end
`endif
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign wr_en     = r_wr_en;
  assign N         = r_n;
  assign Zero      = r_z;
  assign C         = r_c;
  assign V         = r_v;

endmodule
